instruction_fetch_stage: RTL and testbench

//  Initiator side of the instruction-memory interface: owns the PC, issues word addresses to

---
 rtl/instruction_fetch_stage_pkg.sv | 19 +
 rtl/instruction_fetch_stage_if_id_register.sv | 61 ++++++
 rtl/instruction_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// +----------------------------------------------------------------------------+
// | instruction_fetch_stage_pkg : shared widths, NOP encoding and FSM states   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package instruction_fetch_stage_pkg;

  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_stage_if_id_register.sv
// +----------------------------------------------------------------------------+
// | instruction_fetch_stage_if_id_register : IF/ID pipeline register with      |
// | flush (NOP insert), load and bubble controls.  Rev 1.0                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module instruction_fetch_stage_if_id_register
  import instruction_fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic                  bubble_i,
  input  logic [WORD_WIDTH-1:0] instr_i,
  input  logic [WORD_WIDTH-1:0] pc_plus4_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [WORD_WIDTH-1:0] pc_plus4_o
);

  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] instr_q, instr_d;
  logic [WORD_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

  // Flush outranks load so a redirect always leaves a NOP behind.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
    end else if (bubble_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// +----------------------------------------------------------------------------+
// | instruction_fetch_stage : PC, fetch FSM and hold buffer feeding IF/ID.     |
// | Optional IF_PERF_COUNTERS_EN adds fetch/flush counters.  Rev 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_WIDTH-1:0] PC_STEP  = 32'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  output logic                  imem_req_o,
  output logic [WORD_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic [WORD_WIDTH-1:0] imem_rdata_i,
  output logic                  if_id_valid_o,
  output logic [WORD_WIDTH-1:0] if_id_instr_o,
  output logic [WORD_WIDTH-1:0] if_id_pc_plus4_o
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [WORD_WIDTH-1:0] fetch_count_o,
  output logic [WORD_WIDTH-1:0] flush_count_o
`endif
);

  fetch_state_e          state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic [WORD_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_WIDTH-1:0] hold_pc4_q, hold_pc4_d;
  logic [WORD_WIDTH-1:0] w_pc_next;
  logic                  w_load, w_flush, w_bubble;
  logic [WORD_WIDTH-1:0] w_ifid_instr, w_ifid_pc4;

  assign w_pc_next = pc_q + PC_STEP;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    w_bubble     = 1'b0;
    w_ifid_instr = imem_rdata_i;
    w_ifid_pc4   = w_pc_next;
    if (branch_taken_i) begin
      // Redirect wins over everything; any word returned this cycle is dropped.
      pc_d         = branch_target_i & ~32'h3;
      w_flush      = 1'b1;
      hold_instr_d = NOP_INSTR;
      hold_pc4_d   = '0;
      state_d      = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready_i) begin
            if (stall_i) begin
              hold_instr_d = imem_rdata_i;
              hold_pc4_d   = w_pc_next;
              state_d      = ST_HOLD;
            end else begin
              w_load = 1'b1;
              pc_d   = w_pc_next;
            end
          end else if (!stall_i) begin
            w_bubble = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            w_load       = 1'b1;
            w_ifid_instr = hold_instr_q;
            w_ifid_pc4   = hold_pc4_q;
            pc_d         = w_pc_next;
            state_d      = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  // Address and request come straight from registers, so they only move on edges.
  assign imem_req_o  = (state_q == ST_FETCH);
  assign imem_addr_o = {2'b00, pc_q[WORD_WIDTH-1:2]};

  instruction_fetch_stage_if_id_register u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_load),
    .flush_i    (w_flush),
    .bubble_i   (w_bubble),
    .instr_i    (w_ifid_instr),
    .pc_plus4_i (w_ifid_pc4),
    .valid_o    (if_id_valid_o),
    .instr_o    (if_id_instr_o),
    .pc_plus4_o (if_id_pc_plus4_o)
  );

`ifdef IF_PERF_COUNTERS_EN
  logic [WORD_WIDTH-1:0] fetch_cnt_q, flush_cnt_q;
  logic                  w_word_accept;

  assign w_word_accept = !branch_taken_i && (state_q == ST_FETCH) && imem_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_word_accept)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (branch_taken_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign flush_count_o = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// +----------------------------------------------------------------------------+
// | tb_instruction_fetch_stage : directed + random bench with reference model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        ready = 1'b1;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc4;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the fetch stage must hold according to the rules.
  logic [31:0] m_pc;
  logic        m_held;
  logic [31:0] m_held_word, m_held_pc4;
  logic        m_valid;
  logic [31:0] m_instr, m_pc4;
  logic [31:0] m_fetches, m_flushes;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign rdata = ready ? mem_word(addr) : 32'hBAD0_BAD0;

  instruction_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .branch_taken_i   (br),
    .branch_target_i  (tgt),
    .imem_req_o       (req),
    .imem_addr_o      (addr),
    .imem_ready_i     (ready),
    .imem_rdata_i     (rdata),
    .if_id_valid_o    (valid),
    .if_id_instr_o    (instr),
    .if_id_pc_plus4_o (pc4)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .fetch_count_o    (fetch_cnt),
    .flush_count_o    (flush_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_held = 1'b0; m_held_word = 32'h0; m_held_pc4 = 32'h0;
    m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_fetches = 32'h0; m_flushes = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (br) begin
      m_flushes++;
      m_pc = {tgt[31:2], 2'b00};
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_held = 1'b0;
    end else if (m_held) begin
      if (!stall) begin
        m_valid = 1'b1; m_instr = m_held_word; m_pc4 = m_held_pc4;
        m_pc = m_pc + 32'd4;
        m_held = 1'b0;
      end
    end else if (ready) begin
      m_fetches++;
      w = mem_word(m_pc >> 2);
      if (stall) begin
        m_held = 1'b1; m_held_word = w; m_held_pc4 = m_pc + 32'd4;
      end else begin
        m_valid = 1'b1; m_instr = w; m_pc4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
      end
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("req", {31'b0, req}, {31'b0, !m_held});
    chk("addr", addr, m_pc >> 2);
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("instr", instr, m_instr);
      chk("pc_plus4", pc4, m_pc4);
    end
`ifdef IF_PERF_COUNTERS_EN
    chk("fetch_count", fetch_cnt, m_fetches);
    chk("flush_count", flush_cnt, m_flushes);
`endif
  endtask

  task automatic cycle(input logic s, input logic b, input logic [31:0] t, input logic r);
    stall = s; br = b; tgt = t; ready = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();
    chk("rst_req", {31'b0, req}, 32'd1);
    chk("rst_addr", addr, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc4", pc4, 32'd0);

    // Sequential fetch from a zero-wait memory
    for (int k = 0; k < 4; k++) begin
      chk("t1_addr", addr, k);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t1_pc4", pc4, 4 * (k + 1));
      chk("t1_instr", instr, mem_word(k));
    end

    // Stall at pc=8 with IF/ID holding word 1
    cycle(1'b0, 1'b1, 32'd4, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_addr_pre", addr, 32'd2);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      chk("t2_req_hold", {31'b0, req}, 32'd0);
      chk("t2_addr_hold", addr, 32'd2);
      chk("t2_frozen", instr, mem_word(1));
      chk("t2_frozen_pc4", pc4, 32'd8);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_release_instr", instr, mem_word(2));
    chk("t2_release_pc4", pc4, 32'd12);
    chk("t2_release_addr", addr, 32'd3);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_next_instr", instr, mem_word(3));
    chk("t2_next_pc4", pc4, 32'd16);

    // Branch overrides a concurrent stall
    cycle(1'b1, 1'b1, 32'd36, 1'b1);
    chk("t3_valid", {31'b0, valid}, 32'd0);
    chk("t3_instr_nop", instr, 32'd0);
    chk("t3_addr", addr, 32'd9);
    chk("t3_req", {31'b0, req}, 32'd1);

    // Wait states at pc=12
    cycle(1'b0, 1'b1, 32'd12, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      chk("t4_addr_wait", addr, 32'd3);
      chk("t4_bubble", {31'b0, valid}, 32'd0);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t4_accept_valid", {31'b0, valid}, 32'd1);
    chk("t4_accept_instr", instr, mem_word(3));
    chk("t4_accept_pc4", pc4, 32'd16);

    // PC wraps at the top of the address space; low target bits ignored
    cycle(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1);
    chk("wrap_addr_top", addr, 32'h3FFF_FFFF);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc4", pc4, 32'h0);
    chk("wrap_addr", addr, 32'h0);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      cycle($urandom_range(99) < 30, $urandom_range(99) < 8, $urandom, $urandom_range(99) < 70);
    end

    // Asynchronous reset while in HOLD
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t5_in_hold", {31'b0, req}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid_async", {31'b0, valid}, 32'd0);
    chk("t5_instr_async", instr, 32'd0);
    chk("t5_pc4_async", pc4, 32'd0);
    chk("t5_addr_async", addr, 32'd0);
    model_reset();
    stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();
    chk("t5_first_addr", addr, 32'd0);
    chk("t5_first_req", {31'b0, req}, 32'd1);

`ifdef IF_PERF_COUNTERS_EN
    chk("t6_fetch_zero", fetch_cnt, 32'd0);
    chk("t6_flush_zero", flush_cnt, 32'd0);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h40, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h80, 1'b1);
    chk("t6_fetch_count", fetch_cnt, 32'd10);
    chk("t6_flush_count", flush_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
